// File: rtl/wave_profile_buffer_if.sv
// Write port of the wave profile buffer: game logic pushes one
// {wr_index, wr_data} column update per accepted transfer.
interface wave_profile_buffer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10
) ();
  // Handshake: a transfer happens on a rising vclock edge where
  // wr_valid & wr_ready are both high. The writer holds wr_index/wr_data
  // stable while wr_valid is high and not yet accepted. wr_ready depends
  // only on the buffer state, never on wr_valid.
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_index;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_index,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_index,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/wave_profile_buffer.sv
// Double-buffered wave profile store. The writer fills the back bank and
// requests a commit; the banks swap and the scroll offset is latched at the
// next falling edge of vsync. The display reads the front bank with one
// cycle of latency.
module wave_profile_buffer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter int CENTER = 382
) (
  input  logic                 vclock,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic                 vsync,
  input  logic [10:0]          p_offset,
  input  logic                 commit,
  wave_profile_buffer_if.slave wr,
  output logic [DATA_W-1:0]    wave_prof,
  output logic                 front_sel,
  output logic                 swapped,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] CENTER_V = DATA_W'(CENTER);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              wr_ready_c;
  logic [ADDR_W-1:0] init_cnt;
  logic              vsync_d;
  logic              fe;
  logic              swap_now;
  logic              wr_fire;
  logic [10:0]       offset_r;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0] bank0 [0:DEPTH-1];
  logic [DATA_W-1:0] bank1 [0:DEPTH-1];

  assign fe          = vsync_d & ~vsync;
  assign swap_now    = (state_q == PENDING) & fe;
  assign wr_fire     = wr.wr_valid & wr_ready_c;
  assign wr.wr_ready = wr_ready_c;
  assign state_dbg   = state_q;
  // The sum wraps modulo the profile depth; hcount beyond the visible area
  // simply wraps as well.
  assign rd_addr     = ADDR_W'(hcount + offset_r);

  // Delay vsync by one cycle for falling-edge detection.
  always_ff @(posedge vclock) begin
    if (reset) vsync_d <= 1'b1;
    else       vsync_d <= vsync;
  end

  // State register.
  always_ff @(posedge vclock) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // Next state and handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    wr_ready_c = 1'b0;
    busy       = 1'b1;
    case (state_q)
      INIT: begin
        if (&init_cnt) state_d = IDLE;
      end
      IDLE: begin
        wr_ready_c = 1'b1;
        busy       = 1'b0;
        // A commit arriving on a frame edge waits for the next edge.
        if (commit) state_d = PENDING;
      end
      PENDING: begin
        if (fe) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // Clear-address counter, walks every column once during INIT.
  always_ff @(posedge vclock) begin
    if (reset)                 init_cnt <= '0;
    else if (state_q == INIT)  init_cnt <= init_cnt + 1'b1;
  end

  // Bank swap, offset capture and the one-cycle swap pulse.
  always_ff @(posedge vclock) begin
    if (reset) begin
      front_sel <= 1'b0;
      offset_r  <= '0;
      swapped   <= 1'b0;
    end else begin
      swapped <= swap_now;
      if (swap_now) begin
        front_sel <= ~front_sel;
        offset_r  <= p_offset;
      end
    end
  end

  // Bank writes: INIT clears both banks, IDLE writes only the back bank.
  always_ff @(posedge vclock) begin
    if (!reset) begin
      if (state_q == INIT) begin
        bank0[init_cnt] <= CENTER_V;
        bank1[init_cnt] <= CENTER_V;
      end else if (wr_fire) begin
        if (front_sel) bank0[wr.wr_index] <= wr.wr_data;
        else           bank1[wr.wr_index] <= wr.wr_data;
      end
    end
  end

  // Registered front-bank read; banks are not valid until INIT completes.
  always_ff @(posedge vclock) begin
    if (reset || state_q == INIT) wave_prof <= CENTER_V;
    else if (front_sel)           wave_prof <= bank1[rd_addr];
    else                          wave_prof <= bank0[rd_addr];
  end

endmodule

// File: doc/wave_profile_buffer.md
Name: wave_profile_buffer

Overview:
- Double-buffered store for the wave profile: one 10-bit vertical boundary per screen column.
- Game logic writes the next frame's profile into the back bank through a valid/ready port and requests a commit.
- At the next frame boundary (falling edge of vsync) the block swaps banks and latches the horizontal scroll offset together with the swap.
- The read side serves wave_prof for the current hcount with one cycle of latency, so the display pipeline gets a stable, tear-free profile for each frame.

Parameters:
ADDR_W, 10, log2 of profile depth (1024 columns)
DATA_W, 10, profile entry width (vertical pixel row)
CENTER, 382, value loaded into every entry at reset; also the reset value of wave_prof

Ports:
vclock  input  1  pixel clock, 65 MHz
reset  input  1  synchronous, active-high
hcount  input  11  current pixel column
vsync  input  1  active-low vertical sync, same timing as the display's vsync
p_offset  input  11  requested horizontal scroll; sampled only at swap
wr_valid  input  1  write request
wr_ready  output  1  write accepted when wr_valid & wr_ready
wr_index  input  ADDR_W  column to write in the back bank
wr_data  input  DATA_W  profile value
commit  input  1  single-cycle request to swap at the next frame boundary
wave_prof  output  DATA_W  front-bank profile for the column addressed by hcount
front_sel  output  1  index of the current front bank
swapped  output  1  one-cycle pulse on the cycle the swap takes effect
busy  output  1  high during INIT and PENDING

Behaviour:
- Storage: two banks, each 2^ADDR_W x DATA_W. The back bank is the complement of front_sel.
- Frame edge detect:
  - vsync_d is registered every cycle; reset value 1.
  - fe = vsync_d & ~vsync.
- State machine, states INIT, IDLE, PENDING. Reset enters INIT.
  - INIT:
    - A 10-bit counter from 0 writes CENTER to the same address in both banks each cycle.
    - After address 1023 is written, go to IDLE. INIT lasts exactly 1024 cycles.
    - wr_ready=0 and busy=1 throughout.
    - commit and fe are ignored.
  - IDLE:
    - wr_ready=1, busy=0.
    - A handshake writes wr_data to back[wr_index] at the clock edge.
    - commit moves to PENDING. If a write handshake and commit occur in the same cycle, the write is performed, then the state moves to PENDING.
    - fe without a pending commit: no swap; offset is unchanged.
  - PENDING:
    - wr_ready=0, busy=1. Further commits are ignored.
    - On fe: toggle front_sel, latch offset_r <= p_offset, pulse swapped=1 for exactly one cycle, return to IDLE.
    - If commit and fe arrive in the same IDLE cycle, the swap waits for the following fe. There is no same-cycle commit-and-swap.
  - Reset mid-operation, from any state: return to INIT and re-clear both banks.
- After a swap, the new back bank holds the previous front data. No copy is performed; the writer must rewrite every column it needs changed.
- Read path:
  - addr = (hcount + offset_r) truncated to ADDR_W bits, so it wraps modulo 1024 (11-bit sum, low 10 bits used).
  - wave_prof <= front[addr], registered; valid one cycle after hcount.
  - hcount values >= 1024 wrap the same way; there is no special blanking handling.
  - During INIT, wave_prof = CENTER.
  - A swap changes the read bank starting with the read issued in the cycle after the fe cycle.
- Reset values: wave_prof=CENTER, front_sel=0, offset_r=0, swapped=0, wr_ready=0, busy=1.
- A write to index i during PENDING is impossible (wr_ready=0). A write in IDLE never affects the front bank.

Test Plan:
- Reset, then hold vsync high -> busy=1 and wr_ready=0 for exactly 1024 cycles; afterwards wave_prof=382 for hcount 0..1023 and front_sel=0.
- Write index 5 = 100, commit, pulse vsync low -> swapped pulses once, front_sel=1; with hcount=5, wave_prof=100 one cycle later. Before the fe, hcount=5 gave 382.
- p_offset=1020 at swap, back bank entry 2 = 77 -> hcount=6 gives wave_prof=77 ((6+1020) mod 1024 = 2). Changing p_offset mid-frame has no effect until the next swap.
- In IDLE, fe with no commit -> front_sel unchanged, swapped stays 0. In PENDING, wr_valid held high -> wr_ready=0 and the write has no effect after the swap.
- commit and fe in the same IDLE cycle -> no swap at that edge; swap occurs at the next fe. Write and commit in the same cycle -> the data is present after that swap.
- Assert reset while PENDING -> INIT re-clears both banks; all reads return 382, front_sel=0, and no swapped pulse occurs.
